// File: rtl/encoder_16x4_stream_if.sv
// Stream bundle for the 16x4 encoder: request-vector input side plus index output side.
// Optional y_zero exists only when ENC_ZERO_FLAG_EN is defined.
interface encoder_16x4_stream_if #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
);
  logic [N-1:0]     d_in;
  logic             d_valid;
  logic             d_ready;
  logic [IDX_W-1:0] y_out;
  logic             y_valid;
  logic             y_ready;
  logic             y_last;
  logic [IDX_W:0]   y_remain;
`ifdef ENC_ZERO_FLAG_EN
  logic             y_zero;

  modport master (output d_in, d_valid, y_ready,
                  input  d_ready, y_out, y_valid, y_last, y_remain, y_zero);
  modport slave  (input  d_in, d_valid, y_ready,
                  output d_ready, y_out, y_valid, y_last, y_remain, y_zero);
`else
  modport master (output d_in, d_valid, y_ready,
                  input  d_ready, y_out, y_valid, y_last, y_remain);
  modport slave  (input  d_in, d_valid, y_ready,
                  output d_ready, y_out, y_valid, y_last, y_remain);
`endif
endinterface

// File: rtl/encoder_16x4_stream.sv
// Streams the index of every set bit of a request vector, lowest first, one per beat.
// Index/last/remain are registered; only valid/ready are gated by en. Optional macro: ENC_ZERO_FLAG_EN.
module encoder_16x4_stream #(
  parameter int N = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  encoder_16x4_stream_if.slave    strm,
  output logic                    busy
);
  localparam int IDX_W = $clog2(N);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     pending, pending_nxt;
  logic [IDX_W-1:0] y_out_q;
  logic [IDX_W:0]   y_remain_q;
  logic             y_last_q, last_nxt;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N-1:0] v);
    lowest_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (v[i]) lowest_idx = IDX_W'(i);
  endfunction

  function automatic logic [IDX_W:0] pop_cnt(input logic [N-1:0] v);
    pop_cnt = '0;
    for (int i = 0; i < N; i++)
      pop_cnt = pop_cnt + {{IDX_W{1'b0}}, v[i]};
  endfunction

`ifdef ENC_ZERO_FLAG_EN
  logic zero_q, zero_nxt;
`endif

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
`ifdef ENC_ZERO_FLAG_EN
    zero_nxt    = zero_q;
`endif
    if (en) begin
      case (state)
        IDLE: begin
          if (strm.d_valid) begin
            if (strm.d_in != '0) begin
              pending_nxt = strm.d_in;
              state_nxt   = EMIT;
            end
`ifdef ENC_ZERO_FLAG_EN
            else begin
              zero_nxt  = 1'b1;
              state_nxt = EMIT;
            end
`endif
          end
        end
        EMIT: begin
          if (strm.y_ready) begin
            // x & (x-1) strips the lowest set bit
            pending_nxt = pending & (pending - {{(N-1){1'b0}}, 1'b1});
`ifdef ENC_ZERO_FLAG_EN
            zero_nxt    = 1'b0;
`endif
            if (y_last_q) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef ENC_ZERO_FLAG_EN
  assign last_nxt = (pop_cnt(pending_nxt) == (IDX_W+1)'(1)) | zero_nxt;
`else
  assign last_nxt = (pop_cnt(pending_nxt) == (IDX_W+1)'(1));
`endif

  // Beat fields are precomputed from the next pending word so outputs come straight from flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      y_out_q    <= '0;
      y_remain_q <= '0;
      y_last_q   <= 1'b0;
`ifdef ENC_ZERO_FLAG_EN
      zero_q     <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      y_out_q    <= lowest_idx(pending_nxt);
      y_remain_q <= pop_cnt(pending_nxt);
      y_last_q   <= last_nxt;
`ifdef ENC_ZERO_FLAG_EN
      zero_q     <= zero_nxt;
`endif
    end
  end

  // rst gates d_ready so every output reads 0 while reset is held
  assign strm.d_ready  = en & ~rst & (state == IDLE);
  assign strm.y_valid  = en & (state == EMIT);
  assign strm.y_out    = y_out_q;
  assign strm.y_remain = y_remain_q;
  assign strm.y_last   = y_last_q;
  assign busy          = (state == EMIT);
`ifdef ENC_ZERO_FLAG_EN
  assign strm.y_zero   = zero_q;
`endif
endmodule

// File: tb/tb_encoder_16x4_stream.sv
// Self-checking bench for encoder_16x4_stream: vector table, hand sequences, random vectors vs index-list model.
// Works with or without ENC_ZERO_FLAG_EN.
module tb_encoder_16x4_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic busy;
  int   n_cmp = 0;
  int   n_err = 0;

  encoder_16x4_stream_if #(.N(16)) bus ();

  encoder_16x4_stream #(.N(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .strm (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] vec;
    bit          toggle;
    int          n_beats;
    int          first_idx;
    int          last_idx;
  } vec_rec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] decoder_4x16(input logic [3:0] i);
    logic [15:0] one;
    one = 16'h0001;
    return one << i;
  endfunction

  task automatic send_vec(input logic [15:0] v);
    @(negedge clk);
    bus.d_in    = v;
    bus.d_valid = 1'b1;
    #1;
    chk("d_ready_idle", {31'b0, bus.d_ready}, 32'd1);
    @(negedge clk);
    bus.d_valid = 1'b0;
    bus.d_in    = 16'($urandom);
  endtask

  // Model: the list of set-bit positions in ascending order, consumed front to back
  task automatic xfer_vec(input logic [15:0] v, input bit toggle,
                          output int nb, output logic [15:0] orv,
                          output int first_idx, output int last_idx);
    int idx_q[$];
    int cyc;
    bit rdy;
    for (int i = 0; i < 16; i++) if (v[i]) idx_q.push_back(i);
    nb = 0; orv = '0; first_idx = -1; last_idx = -1;
    send_vec(v);
    rdy = !toggle;
    cyc = 0;
    while (nb < idx_q.size() && cyc < 64) begin
      bus.y_ready = rdy;
      #1;
      chk("beat_valid",  {31'b0, bus.y_valid}, 32'd1);
      chk("beat_y_out",  32'(bus.y_out), 32'(idx_q[nb]));
      chk("beat_remain", 32'(bus.y_remain), 32'(idx_q.size() - nb));
      chk("beat_last",   {31'b0, bus.y_last}, {31'b0, (nb == idx_q.size() - 1)});
      chk("beat_d_ready", {31'b0, bus.d_ready}, 32'd0);
      chk("beat_busy",   {31'b0, busy}, 32'd1);
`ifdef ENC_ZERO_FLAG_EN
      chk("beat_y_zero", {31'b0, bus.y_zero}, 32'd0);
`endif
      if (rdy) begin
        if (nb == 0) first_idx = int'(bus.y_out);
        last_idx = int'(bus.y_out);
        orv = orv | decoder_4x16(bus.y_out);
        nb++;
      end
      if (toggle) rdy = !rdy;
      cyc++;
      @(negedge clk);
    end
    bus.y_ready = 1'b1;
    #1;
    chk("beat_count",   32'(nb), 32'(idx_q.size()));
    chk("after_valid",  {31'b0, bus.y_valid}, 32'd0);
    chk("after_d_ready", {31'b0, bus.d_ready}, 32'd1);
  endtask

  vec_rec_t tbl[6];
  int       nb, fi, li, k, gap, cyc;
  logic [15:0] orv, v;

  initial begin
    tbl[0] = '{vec: 16'hA005, toggle: 1'b0, n_beats: 4,  first_idx: 0,  last_idx: 15};
    tbl[1] = '{vec: 16'h0110, toggle: 1'b1, n_beats: 2,  first_idx: 4,  last_idx: 8};
    tbl[2] = '{vec: 16'h8000, toggle: 1'b0, n_beats: 1,  first_idx: 15, last_idx: 15};
    tbl[3] = '{vec: 16'h0001, toggle: 1'b1, n_beats: 1,  first_idx: 0,  last_idx: 0};
    tbl[4] = '{vec: 16'hFFFF, toggle: 1'b0, n_beats: 16, first_idx: 0,  last_idx: 15};
    tbl[5] = '{vec: 16'h1234, toggle: 1'b1, n_beats: 5,  first_idx: 2,  last_idx: 12};

    bus.d_in = '0; bus.d_valid = 1'b0; bus.y_ready = 1'b0;
    #1;
    chk("rst_d_ready",  {31'b0, bus.d_ready}, 32'd0);
    chk("rst_y_valid",  {31'b0, bus.y_valid}, 32'd0);
    chk("rst_y_out",    32'(bus.y_out), 32'd0);
    chk("rst_y_remain", 32'(bus.y_remain), 32'd0);
    chk("rst_busy",     {31'b0, busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      xfer_vec(tbl[i].vec, tbl[i].toggle, nb, orv, fi, li);
      chk("tbl_beats", 32'(nb), 32'(tbl[i].n_beats));
      chk("tbl_first", 32'(fi), 32'(tbl[i].first_idx));
      chk("tbl_last",  32'(li), 32'(tbl[i].last_idx));
      chk("tbl_or",    32'(orv), 32'(tbl[i].vec));
    end

    // Reset mid-EMIT after one beat of 16'h00F0
    send_vec(16'h00F0);
    bus.y_ready = 1'b1;
    #1;
    chk("rstm_beat0", 32'(bus.y_out), 32'd4);
    @(negedge clk);
    bus.y_ready = 1'b0;
    #1;
    chk("rstm_beat1", 32'(bus.y_out), 32'd5);
    chk("rstm_rem1",  32'(bus.y_remain), 32'd3);
    rst = 1'b1;
    #1;
    chk("rstm_d_ready", {31'b0, bus.d_ready}, 32'd0);
    chk("rstm_y_valid", {31'b0, bus.y_valid}, 32'd0);
    chk("rstm_y_out",   32'(bus.y_out), 32'd0);
    chk("rstm_y_last",  {31'b0, bus.y_last}, 32'd0);
    chk("rstm_y_remain", 32'(bus.y_remain), 32'd0);
    chk("rstm_busy",    {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.y_ready = 1'b1;
    #1;
    chk("rstm_rel_d_ready", {31'b0, bus.d_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rstm_no_stale", {31'b0, bus.y_valid}, 32'd0);
    end

    // en dropped for 3 cycles after beat 5 of an all-ones vector
    send_vec(16'hFFFF);
    k = 0; gap = 0; cyc = 0;
    while (k < 16 && cyc < 100) begin
      bus.y_ready = 1'b1;
      if (k == 5 && gap < 3) begin
        en = 1'b0;
        #1;
        chk("en_gap_valid",   {31'b0, bus.y_valid}, 32'd0);
        chk("en_gap_d_ready", {31'b0, bus.d_ready}, 32'd0);
        chk("en_gap_y_out",   32'(bus.y_out), 32'd5);
        gap++;
      end else begin
        en = 1'b1;
        #1;
        chk("en_valid",  {31'b0, bus.y_valid}, 32'd1);
        chk("en_y_out",  32'(bus.y_out), 32'(k));
        chk("en_remain", 32'(bus.y_remain), 32'(16 - k));
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    en = 1'b1;
    #1;
    chk("en_beats", 32'(k), 32'd16);
    chk("en_gap_len", 32'(gap), 32'd3);
    chk("en_after_valid", {31'b0, bus.y_valid}, 32'd0);

    // Zero vector
`ifdef ENC_ZERO_FLAG_EN
    send_vec(16'h0000);
    bus.y_ready = 1'b0;
    #1;
    chk("zero_valid",  {31'b0, bus.y_valid}, 32'd1);
    chk("zero_flag",   {31'b0, bus.y_zero}, 32'd1);
    chk("zero_last",   {31'b0, bus.y_last}, 32'd1);
    chk("zero_y_out",  32'(bus.y_out), 32'd0);
    chk("zero_remain", 32'(bus.y_remain), 32'd0);
    @(negedge clk);
    bus.y_ready = 1'b1;
    #1;
    chk("zero_hold_flag", {31'b0, bus.y_zero}, 32'd1);
    @(negedge clk); #1;
    chk("zero_done_valid", {31'b0, bus.y_valid}, 32'd0);
    chk("zero_done_flag",  {31'b0, bus.y_zero}, 32'd0);
    chk("zero_done_ready", {31'b0, bus.d_ready}, 32'd1);
`else
    xfer_vec(16'h0000, 1'b0, nb, orv, fi, li);
    chk("zero_beats", 32'(nb), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("zero_no_valid", {31'b0, bus.y_valid}, 32'd0);
    end
`endif
    xfer_vec(16'h0003, 1'b0, nb, orv, fi, li);
    chk("post_zero_or", 32'(orv), 32'h0003);

    // Random vectors, beats re-decoded and ORed back together
    for (int r = 0; r < 40; r++) begin
      v = 16'($urandom);
      if (v == 16'h0000) v = 16'h0400;
      xfer_vec(v, 1'($urandom), nb, orv, fi, li);
      chk("rand_or",    32'(orv), 32'(v));
      chk("rand_beats", 32'(nb), 32'($countones(v)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/encoder_16x4_stream.md
Name: encoder_16x4_stream

Overview:
- Inverse of the 4x16 decoder: accepts a 16-bit multi-hot request word and emits the 4-bit index of every set bit, one index per beat, lowest index first.
- Sits between a bit-vector source (status or request masks) and any consumer that needs binary indices.
- Both sides use a valid/ready handshake.
- The en gate matches the decoder's enable semantics.

Parameters:
- N, 16, input vector width; must be a power of 2, at least 2.
- IDX_W, $clog2(N), output index width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  global enable; low freezes all state
- d_in  input  N  request vector
- d_valid  input  1  d_in is valid
- d_ready  output  1  block can accept a vector
- y_out  output  IDX_W  index of the lowest pending set bit
- y_valid  output  1  y_out is valid
- y_ready  input  1  consumer accepts y_out
- y_last  output  1  current beat is the final index of this vector
- y_remain  output  IDX_W+1  number of set bits still pending, including the current one
- busy  output  1  state is EMIT

Behaviour:
- Reset (async assert, sync release): state=IDLE, pending=0.
  - All outputs read 0: d_ready=0, y_valid=0, y_out=0, y_last=0, y_remain=0, busy=0.
  - Reset mid-EMIT discards the pending vector immediately with no further beats.
- State IDLE:
  - d_ready = en.
  - Accept on a rising edge when en & d_valid & d_ready.
  - If d_in != 0: pending <= d_in, state <= EMIT.
  - If d_in == 0: handled per the Optional Feature.
- State EMIT:
  - d_ready = 0, y_valid = en, busy = 1.
  - y_out = index of the lowest set bit in pending (bit 0 has highest priority).
  - y_remain = popcount(pending).
  - y_last = (y_remain == 1).
- Output transfer: on a rising edge with en & y_valid & y_ready, clear the lowest set bit of pending.
  - If y_last, go to IDLE.
  - If not y_last, stay in EMIT.
- Latency and throughput:
  - First index is valid in the cycle after the input is accepted.
  - One index per cycle while y_ready is high.
  - No back-to-back input acceptance: the block returns to IDLE for at least one cycle, giving a total of popcount+1 cycles per vector.
- Stability: while y_valid=1 and y_ready=0, y_out, y_last and y_remain hold stable.
- en low:
  - d_ready=0 and y_valid=0, no state or pending change; handshakes are ignored.
  - Resuming en restores the exact prior outputs.
- Output timing: all outputs are functions of the state/pending registers only, with no combinational path from d_in or y_ready. The one exception is gating by en.
- Boundary values:
  - d_in = all ones gives 16 beats, indices 0..15; y_remain counts 16 down to 1.
  - d_in = 16'h8000 gives a single beat: y_out=15, y_last=1, y_remain=1.
- Width rule: y_remain is IDX_W+1 bits so that a value of N is representable.

Optional Feature:
- Macro: ENC_ZERO_FLAG_EN.
- Defined:
  - Adds output port y_zero (1 bit, reset 0).
  - Accepting d_in == 0 enters EMIT for exactly one beat with y_zero=1, y_out=0, y_last=1, y_remain=0. The transfer returns the block to IDLE.
  - y_zero is 0 on all other beats.
- Undefined:
  - Port y_zero is absent.
  - A zero vector is accepted (one-cycle handshake) and dropped; the block stays in IDLE and y_valid stays 0.

Test Plan:
1. Reset check: assert rst mid-EMIT with d_in=16'h00F0 accepted and one beat transferred. Required: all outputs 0 asynchronously. After release, d_ready=en and no stale beats appear.
2. Multi-bit vector, y_ready=1: d_in=16'hA005, en=1. Required beats y_out=0,2,13,15 on consecutive cycles; y_remain=4,3,2,1; y_last only on 15. d_ready is 0 throughout, then 1 the cycle after.
3. Backpressure: d_in=16'h0110, y_ready toggling every cycle starting at 0. Required: y_out=4 held until accepted, then y_out=8 with y_last=1; exactly two transfers.
4. en gating: d_in=16'hFFFF, drop en for 3 cycles after beat 5. Required: y_valid=0 during the gap, y_out=5 and y_remain=11 on resume, 16 beats in total.
5. Boundary vectors:
   - d_in=16'h8000: single beat y_out=15, y_last=1.
   - d_in=16'h0001: single beat y_out=0.
   - Randomized $urandom vectors: the scoreboard re-decodes the beats through decoder_4x16 and ORs them; the result must equal d_in.
6. Zero vector, run with and without ENC_ZERO_FLAG_EN: d_in=16'h0000. Required:
   - Defined: one beat with y_zero=1, y_last=1.
   - Undefined: no y_valid, and the next vector is accepted normally.
